// File: rtl/cpu_load_store_unit_if.sv
// Memory-side bus between the load/store unit and the CPU memory access stage.
// master: the load/store unit. It drives the level requests, the word address,
//         the byte mask and the store data.
// slave:  the memory access stage. It returns the read word and mem_done.
//         mem_done stays high until both requests drop.
interface cpu_load_store_unit_if;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned MASK_W = DATA_W / 8;

  logic              mem_rd_req;
  logic              mem_wr_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_out;
  logic [MASK_W-1:0] mem_data_mask;
  logic [DATA_W-1:0] mem_data_in;
  logic              mem_done;

  modport master (
    output mem_rd_req, mem_wr_req, mem_addr, mem_data_out, mem_data_mask,
    input  mem_data_in, mem_done
  );

  modport slave (
    input  mem_rd_req, mem_wr_req, mem_addr, mem_data_out, mem_data_mask,
    output mem_data_in, mem_done
  );
endinterface

// File: rtl/cpu_load_store_unit.sv
// cpu_load_store_unit: turns RV32 load/store requests (funct3 size code, byte
// address) into aligned word transactions for the memory access stage.
// On the way out it builds byte masks and lane-shifted store data. On the way
// back it extracts, shifts and extends the load data.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   start           request strobe, sampled only in IDLE
//   is_store        1 = store, 0 = load
//   funct3          000 B, 001 H, 010 W, 100 BU, 101 HU
//   addr            byte address
//   store_data      right-aligned store value
//   load_data       extended load result; held until the next load completes
//   busy            high in every state except IDLE
//   done, fault     one-cycle completion pulse; fault marks a rejected access
//   bus             memory access stage handshake (master side)
//
// Build option CPU_LSU_MISALIGN_TRAP_EN:
//   defined   - misaligned H/HU/W accesses fault and make no bus access.
//   undefined - misaligned accesses are forced down to natural alignment
//               and then proceed normally.
module cpu_load_store_unit (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  is_store,
  input  logic [2:0]            funct3,
  input  logic [31:0]           addr,
  input  logic [31:0]           store_data,
  output logic [31:0]           load_data,
  output logic                  busy,
  output logic                  done,
  output logic                  fault,
  cpu_load_store_unit_if.master bus
);
  localparam int unsigned DATA_W = 32;
  localparam int unsigned MASK_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_DONE    = 2'd1,
    WAIT_RELEASE = 2'd2,
    FINISH       = 2'd3
  } state_t;

  state_t            state;
  logic [2:0]        funct3_q;
  logic [1:0]        off_q;
  logic              store_q;

  logic              reject_c;
  logic [1:0]        off_c;
  logic [MASK_W-1:0] mask_c;
  logic [DATA_W-1:0] wdata_c;
  logic [DATA_W-1:0] rshift_c;
  logic [DATA_W-1:0] rext_c;

  // Request decode: legality, effective byte offset, byte mask and store lanes.
  always_comb begin
    reject_c = (funct3[1:0] == 2'b11) || (funct3[2:1] == 2'b11) ||
               (is_store && funct3[2]);
    off_c    = addr[1:0];
    mask_c   = MASK_W'(4'b1111);
    case (funct3[1:0])
      2'b00: begin
        off_c  = addr[1:0];
        mask_c = MASK_W'(4'b0001 << off_c);
      end
      2'b01: begin
        off_c  = {addr[1], 1'b0};
        mask_c = MASK_W'(4'b0011 << off_c);
      end
      default: begin
        off_c  = 2'b00;
        mask_c = MASK_W'(4'b1111);
      end
    endcase
`ifdef CPU_LSU_MISALIGN_TRAP_EN
    if ((funct3[1:0] == 2'b01 && addr[0]) ||
        (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00)) begin
      reject_c = 1'b1;
    end
`endif
    wdata_c = store_data << {off_c, 3'b000};
  end

  // Load return path: bring the addressed lane down to bit 0, then extend.
  always_comb begin
    rshift_c = bus.mem_data_in >> {off_q, 3'b000};
    case (funct3_q)
      3'b000:  rext_c = {{24{rshift_c[7]}}, rshift_c[7:0]};
      3'b001:  rext_c = {{16{rshift_c[15]}}, rshift_c[15:0]};
      3'b100:  rext_c = {24'd0, rshift_c[7:0]};
      3'b101:  rext_c = {16'd0, rshift_c[15:0]};
      default: rext_c = rshift_c;
    endcase
  end

  // Handshake FSM. Every output is registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      funct3_q          <= 3'd0;
      off_q             <= 2'd0;
      store_q           <= 1'b0;
      load_data         <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      fault             <= 1'b0;
      bus.mem_rd_req    <= 1'b0;
      bus.mem_wr_req    <= 1'b0;
      bus.mem_addr      <= '0;
      bus.mem_data_out  <= '0;
      bus.mem_data_mask <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (reject_c) begin
              state <= FINISH;
              done  <= 1'b1;
              fault <= 1'b1;
            end else begin
              state             <= WAIT_DONE;
              funct3_q          <= funct3;
              off_q             <= off_c;
              store_q           <= is_store;
              bus.mem_addr      <= {addr[31:2], 2'b00};
              bus.mem_data_mask <= mask_c;
              bus.mem_data_out  <= wdata_c;
              bus.mem_rd_req    <= ~is_store;
              bus.mem_wr_req    <= is_store;
            end
          end
        end
        WAIT_DONE: begin
          if (bus.mem_done) begin
            bus.mem_rd_req <= 1'b0;
            bus.mem_wr_req <= 1'b0;
            if (!store_q) begin
              load_data <= rext_c;
            end
            state <= WAIT_RELEASE;
          end
        end
        WAIT_RELEASE: begin
          // The memory stage keeps mem_done high until it sees the requests drop.
          if (!bus.mem_done) begin
            state <= FINISH;
            done  <= 1'b1;
            fault <= 1'b0;
          end
        end
        FINISH: begin
          state <= IDLE;
          done  <= 1'b0;
          fault <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_load_store_unit.sv
// Scoreboard testbench for cpu_load_store_unit.
// The driver pushes the expected bus request and completion into queues.
// A monitor pops and compares each one when the DUT presents it.
// A responder process plays the memory access stage.
module tb_cpu_load_store_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] store_data = 32'd0;
  logic [31:0] load_data;
  logic        busy;
  logic        done;
  logic        fault;

  cpu_load_store_unit_if bus_if ();

  cpu_load_store_unit dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .is_store   (is_store),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .load_data  (load_data),
    .busy       (busy),
    .done       (done),
    .fault      (fault),
    .bus        (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          st;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
  } bus_exp_t;

  typedef struct {
    bit          flt;
    logic [31:0] ld;
  } done_exp_t;

  bus_exp_t    bus_q[$];
  done_exp_t   done_q[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          drop_cyc = 0;
  logic [31:0] ld_model = 32'd0;
  logic [31:0] resp_word = 32'd0;
  int          resp_lat = 0;
  int          resp_hold = 0;
  int          lat_cnt = 0;
  int          hold_cnt = 0;
  bit          prev_req = 1'b0;
  bit          prev_done = 1'b0;
  bus_exp_t    mbe;
  done_exp_t   mde;
  logic [31:0] bmask;
  logic [2:0]  legal_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model. Works on byte positions: an access of n bytes covers the
  // bytes from offset eff up to eff+n-1 of the aligned word.
  function automatic void model(input bit st, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] sd, input logic [31:0] rw,
                                output bit flt, output bus_exp_t be, output logic [31:0] ld);
    int     n;
    int     off;
    int     eff;
    longint val;
    bit     legal;
    n     = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2) || (!st && (f3 == 3'd4 || f3 == 3'd5));
    off   = int'(a % 4);
    flt   = !legal;
`ifdef CPU_LSU_MISALIGN_TRAP_EN
    if (off % n != 0) flt = 1'b1;
`endif
    eff     = off - (off % n);
    be.st   = st;
    be.addr = a - (a % 4);
    be.mask = 4'b0000;
    be.data = 32'd0;
    val     = 0;
    for (int i = 0; i < n; i++) begin
      be.mask[eff+i] = 1'b1;
      be.data = be.data | (((sd >> (8*i)) & 32'hFF) << (8*(eff+i)));
      val = val + longint'((rw >> (8*(eff+i))) & 32'hFF) * (longint'(1) << (8*i));
    end
    if (!f3[2] && n < 4 && val >= (longint'(1) << (8*n-1)))
      val = val - (longint'(1) << (8*n));
    ld = 32'(val);
  endfunction

  // Memory access stage model. It raises mem_done after a programmable latency.
  // It holds mem_done for resp_hold cycles after the requests drop.
  initial begin
    bus_if.mem_done    = 1'b0;
    bus_if.mem_data_in = 32'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        bus_if.mem_done = 1'b0;
        lat_cnt = 0;
      end else if (bus_if.mem_done) begin
        chk("req_drop", {bus_if.mem_rd_req, bus_if.mem_wr_req}, 0);
        if (!(bus_if.mem_rd_req || bus_if.mem_wr_req)) begin
          if (hold_cnt == 0) begin
            bus_if.mem_done    = 1'b0;
            bus_if.mem_data_in = $urandom;
            drop_cyc = cyc;
          end else begin
            hold_cnt--;
          end
        end
      end else if (bus_if.mem_rd_req || bus_if.mem_wr_req) begin
        if (lat_cnt >= resp_lat) begin
          bus_if.mem_data_in = resp_word;
          bus_if.mem_done    = 1'b1;
          hold_cnt = resp_hold;
          lat_cnt  = 0;
        end else begin
          lat_cnt++;
        end
      end
    end
  end

  // Monitor: checks each new request and each completion against the queues.
  always @(negedge clk) begin
    if (rst) begin
      prev_req  = 1'b0;
      prev_done = 1'b0;
    end else begin
      if ((bus_if.mem_rd_req || bus_if.mem_wr_req) && !prev_req) begin
        if (bus_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_req: got request addr %0h expected none", bus_if.mem_addr);
        end else begin
          mbe = bus_q.pop_front();
          chk("req_kind", {bus_if.mem_rd_req, bus_if.mem_wr_req}, {!mbe.st, mbe.st});
          chk("mem_addr", bus_if.mem_addr, mbe.addr);
          chk("mem_mask", bus_if.mem_data_mask, mbe.mask);
          if (mbe.st) begin
            for (int i = 0; i < 4; i++) bmask[8*i +: 8] = mbe.mask[i] ? 8'hFF : 8'h00;
            chk("mem_data_out", bus_if.mem_data_out & bmask, mbe.data);
          end
        end
      end
      prev_req = bus_if.mem_rd_req || bus_if.mem_wr_req;
      if (done) begin
        chk("done_width", prev_done, 0);
        if (done_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done expected none");
        end else begin
          mde = done_q.pop_front();
          chk("fault", fault, mde.flt);
          chk("load_data", load_data, mde.ld);
          chk("busy_at_done", busy, 1);
          if (!mde.flt) chk("done_latency", cyc - drop_cyc, 1);
        end
        done_cnt++;
      end
      prev_done = done;
    end
  end

  task automatic access(input bit st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input logic [31:0] rw,
                        input int lat, input int hold, input bit spur);
    bit          flt;
    bus_exp_t    be;
    logic [31:0] ld;
    done_exp_t   de;
    int          target;
    model(st, f3, a, sd, rw, flt, be, ld);
    if (!flt) begin
      bus_q.push_back(be);
      if (!st) ld_model = ld;
    end
    de.flt = flt;
    de.ld  = ld_model;
    done_q.push_back(de);
    resp_word = rw;
    resp_lat  = lat;
    resp_hold = hold;
    target    = done_cnt + 1;
    @(negedge clk);
    start = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = sd;
    @(negedge clk);
    start = 1'b0; addr = $urandom; store_data = $urandom; funct3 = 3'($urandom);
    if (flt) begin
      chk("reject_timing", {done, fault, busy}, 3'b111);
    end else if (spur) begin
      start = 1'b1; is_store = !st;
      @(negedge clk);
      start = 1'b0;
    end
    for (int i = 0; i < 100 && done_cnt < target; i++) @(negedge clk);
    if (done_cnt < target) begin
      checks++; errors++;
      $display("FAIL timeout: got no done expected done within 100 cycles");
      bus_q.delete();
      done_q.delete();
    end else begin
      @(negedge clk);
      chk("idle_after_done", {busy, done, fault, bus_if.mem_rd_req, bus_if.mem_wr_req}, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          st;
    logic [2:0]  f3;
    logic [31:0] a;
    repeat (2) @(negedge clk);
    chk("rst_reqs", {bus_if.mem_rd_req, bus_if.mem_wr_req, busy, done, fault}, 0);
    chk("rst_load_data", load_data, 0);
    chk("rst_mem_addr", bus_if.mem_addr, 0);
    chk("rst_mem_data_out", bus_if.mem_data_out, 0);
    chk("rst_mask", bus_if.mem_data_mask, 0);
    rst = 1'b0;

    access(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 2, 0, 1'b0); // LW
    access(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF0000, 1, 0, 1'b0); // LB
    access(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF0000, 1, 0, 1'b0); // LBU
    access(1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 2, 0, 1'b0); // SH
    access(1'b0, 3'b010, 32'h101, 32'h0, 32'h11223344, 1, 0, 1'b0); // misaligned LW
    access(1'b1, 3'b100, 32'h300, 32'h55, 32'h0, 1, 0, 1'b0);       // illegal store
    access(1'b0, 3'b001, 32'h102, 32'h0, 32'hC3A50000, 3, 0, 1'b1); // LH + stray start
    access(1'b0, 3'b101, 32'h102, 32'h0, 32'hC3A50000, 0, 0, 1'b0); // LHU
    access(1'b0, 3'b010, 32'h400, 32'h0, 32'h0BADF00D, 1, 5, 1'b0); // long mem_done hold
    access(1'b0, 3'b011, 32'h400, 32'h0, 32'h0, 1, 0, 1'b0);
    access(1'b0, 3'b110, 32'h400, 32'h0, 32'h0, 1, 0, 1'b0);
    access(1'b0, 3'b111, 32'h400, 32'h0, 32'h0, 1, 0, 1'b0);

    for (int k = 0; k < 200; k++) begin
      st = 1'($urandom);
      f3 = ($urandom_range(0, 3) != 0) ? legal_f3[$urandom_range(0, 4)] : 3'($urandom);
      a  = $urandom;
      access(st, f3, a, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
             1'($urandom));
    end

    // Leave a nonzero load result, then reset in the middle of a load.
    access(1'b0, 3'b010, 32'h500, 32'h0, 32'hA5A5A5A5, 0, 0, 1'b0);
    ld_model = 32'd0;
    resp_lat = 20;
    model(1'b0, 3'b010, 32'h600, 32'h0, 32'h0, mde.flt, mbe, bmask);
    bus_q.push_back(mbe);
    @(negedge clk);
    start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h600;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_reqs", {bus_if.mem_rd_req, bus_if.mem_wr_req, busy, done}, 0);
    chk("midrst_load_data", load_data, 0);
    chk("midrst_mask", bus_if.mem_data_mask, 0);
    bus_q.delete();
    done_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    access(1'b0, 3'b000, 32'h701, 32'h0, 32'h00007F00, 1, 1, 1'b0);
    access(1'b1, 3'b010, 32'h704, 32'hCAFEF00D, 32'h0, 1, 0, 1'b0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cpu_load_store_unit.md
# cpu_load_store_unit

Translates CPU load/store requests (RV32 funct3 encoding, byte address) into aligned word transactions for the CPU memory access stage, which owns the system bus. Generates byte masks and lane-shifted store data on the way out; extracts, shifts and sign/zero-extends load data on the way back. Sits between the execute/memory pipeline stage and the memory access stage and runs the request/done handshake that stage requires.

## Interface
Parameters: none.

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  request strobe; sampled only in IDLE
- is_store  in  1  1 = store, 0 = load
- funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only)
- addr  in  32  byte address
- store_data  in  32  store value, right-aligned
- load_data  out  32  extended load result; held until next load completes
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- fault  out  1  valid with done; access rejected, no bus activity
- mem_rd_req, mem_wr_req  out  1  level requests to memory access stage
- mem_addr  out  32  {addr[31:2], 2'b00}
- mem_data_out  out  32  lane-shifted store data
- mem_data_mask  out  4  byte enables, bit i = bits [8i+7:8i] (little-endian)
- mem_data_in  in  32  word returned by memory access stage
- mem_done  in  1  level; held high until both requests drop

## Operation
- States: IDLE, WAIT_DONE, WAIT_RELEASE, FINISH.
- IDLE, start=1, legal and aligned: latch mem_addr, mask, shifted data, funct3, byte offset a=addr[1:0]; assert mem_rd_req (load) or mem_wr_req (store); -> WAIT_DONE.
- IDLE, start=1, rejected: no request; -> FINISH with fault=1.
- Mask: B = 0001<<a; H = 0011<<a; W = 1111. Store data: store_data<<(8*a), upper bytes don't-care outside mask.
- WAIT_DONE, mem_done=1: drop both requests; for loads capture mem_data_in>>(8*a), then B/H sign-extend from bit 7/15, BU/HU zero-extend, W unchanged, into load_data; -> WAIT_RELEASE.
- WAIT_RELEASE: stay while mem_done=1; when 0 -> FINISH.
- FINISH: done=1 for exactly this cycle (fault as decided); -> IDLE.
- Illegal encodings (funct3 011/110/111, or store with funct3[2]=1) always fault.
- Stores leave load_data unchanged.
- start in any state other than IDLE is ignored (no queueing).

## Timing
- Reset values: state IDLE; mem_rd_req, mem_wr_req, done, fault, busy = 0; load_data, mem_addr, mem_data_out = 0; mem_data_mask = 0000.
- All outputs registered; done/fault are state decodes of FINISH.
- Request asserted the cycle after start is sampled; requests drop the cycle after mem_done first seen high.
- Minimum legal access: start edge N, req from N+1, mem_done earliest N+3 (downstream needs bus), done at cycle mem_done_fall+1.
- Rejected access: done/fault high in cycle N+1, busy high in N+1 only.
- Next start accepted in the cycle done is high's following cycle (IDLE).
- rst mid-operation: immediate return to reset values; downstream stage shares rst, so no stale handshake remains.

## Configuration
- CPU_LSU_MISALIGN_TRAP_EN defined: H/HU with a[0]=1, or W with a!=00, fault with no bus access.
- Undefined: misaligned accesses are not faulted; offset forced down to natural alignment (H: a&2'b10, W: a=00) and the access proceeds normally.

## Test plan
- LW addr 0x100, mem_data_in 0xDEADBEEF -> mem_addr 0x100, mask 1111, rd_req only, load_data 0xDEADBEEF, done one cycle, fault 0.
- LB addr 0x103, mem_data_in 0x80FF_0000 -> mask 1000, load_data 0xFFFFFF80; LBU same -> 0x00000080.
- SH addr 0x202, store_data 0x1234ABCD -> mem_addr 0x200, mask 1100, mem_data_out[31:16] 0xABCD, wr_req only; load_data unchanged.
- LW addr 0x101: with CPU_LSU_MISALIGN_TRAP_EN -> done+fault next cycle, no request ever; without -> access at 0x100, mask 1111, fault 0.
- Store funct3 100 -> fault with done, no request; start pulsed during WAIT_DONE -> ignored, exactly one done.
- mem_done held high 5 cycles after requests drop -> stays WAIT_RELEASE, done fires one cycle after mem_done falls; rst asserted in WAIT_DONE -> requests 0 and busy 0 immediately.
